// File: rtl/vend_if.sv
// vend_if: bundles the coin-sensor, request, hopper and actuator signals of the vending controller.
//   Inputs to the controller: penny, nickle, dime, quarter, buy, cancel, hopper_ready.
//   Outputs from the controller: credit[CREDIT_W], busy, dispense, chg_quarter, chg_dime,
//   chg_nickle, chg_penny, reject, short_funds, plus sales_count[16] and
//   change_cents_total[16] when SALES_COUNT_EN is defined.
//   master = stimulus/sensor side, slave = controller side.
interface vend_if #(parameter int CREDIT_W = 8);
   logic                penny, nickle, dime, quarter, buy, cancel, hopper_ready;
   logic [CREDIT_W-1:0] credit;
   logic                busy, dispense, chg_quarter, chg_dime, chg_nickle, chg_penny;
   logic                reject, short_funds;
`ifdef SALES_COUNT_EN
   logic [15:0]         sales_count, change_cents_total;
   modport master (
      output penny, nickle, dime, quarter, buy, cancel, hopper_ready,
      input  credit, busy, dispense, chg_quarter, chg_dime, chg_nickle, chg_penny,
      input  reject, short_funds, sales_count, change_cents_total
   );
   modport slave (
      input  penny, nickle, dime, quarter, buy, cancel, hopper_ready,
      output credit, busy, dispense, chg_quarter, chg_dime, chg_nickle, chg_penny,
      output reject, short_funds, sales_count, change_cents_total
   );
`else
   modport master (
      output penny, nickle, dime, quarter, buy, cancel, hopper_ready,
      input  credit, busy, dispense, chg_quarter, chg_dime, chg_nickle, chg_penny,
      input  reject, short_funds
   );
   modport slave (
      input  penny, nickle, dime, quarter, buy, cancel, hopper_ready,
      output credit, busy, dispense, chg_quarter, chg_dime, chg_nickle, chg_penny,
      output reject, short_funds
   );
`endif
endinterface

// File: rtl/vend_controller.sv
// vend_controller: accumulates coin credit, vends one item at PRICE, returns change greedily.
//   clk, reset (synchronous, active-high) are plain ports; everything else is on bus (vend_if.slave):
//   coin pulses penny/nickle/dime/quarter, buy, cancel, hopper_ready in;
//   credit, busy, dispense, chg_*, reject, short_funds out, all registered.
//   Optional macro SALES_COUNT_EN adds sales_count and change_cents_total (16-bit, wrapping).
module vend_controller #(
   parameter int PRICE      = 65,
   parameter int MAX_CREDIT = 200,
   parameter int CREDIT_W   = 8
) (
   input logic   clk,
   input logic   reset,
   vend_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);
   state_t              state, state_n;
   logic [CREDIT_W-1:0] credit, credit_n, credited, chg_val;
   logic [CREDIT_W:0]   coin_val, sum;
   logic [3:0]          coins, chg_n, chg;
   logic                coin_any, coin_fit, dispense_n, reject_n, short_n;
   logic                busy, dispense, reject, short_funds;
`ifdef SALES_COUNT_EN
   logic [15:0]         sales_count, change_total;
`endif
   assign coins    = {bus.quarter, bus.dime, bus.nickle, bus.penny};
   assign coin_any = |coins;
   assign coin_val = bus.quarter ? (CREDIT_W+1)'(25) :
                     bus.dime    ? (CREDIT_W+1)'(10) :
                     bus.nickle  ? (CREDIT_W+1)'(5)  :
                     bus.penny   ? (CREDIT_W+1)'(1)  : '0;
   assign sum      = {1'b0, credit} + coin_val;
   // only a single-denomination pulse that keeps us under the ceiling is creditable
   assign coin_fit = $onehot(coins) && sum <= MAX_C;
   always_comb begin
      state_n    = state;
      credit_n   = credit;
      credited   = credit;
      chg_val    = '0;
      chg_n      = '0;
      dispense_n = 1'b0;
      reject_n   = 1'b0;
      short_n    = 1'b0;
      case (state)
         IDLE, CREDIT: begin
            reject_n = coin_any && !coin_fit;
            credited = coin_fit ? sum[CREDIT_W-1:0] : credit;
            credit_n = credited;
            if (bus.cancel) begin
               state_n = credited != '0 ? CHANGE : IDLE;
            end else if (bus.buy && credit >= PRICE_C) begin
               // the price test uses registered credit; a same-cycle coin still joins the change
               credit_n   = credited - PRICE_C;
               dispense_n = 1'b1;
               state_n    = VEND;
            end else begin
               short_n = bus.buy;
               state_n = credited != '0 ? CREDIT : IDLE;
            end
         end
         VEND: begin
            reject_n = coin_any;
            state_n  = credit != '0 ? CHANGE : IDLE;
         end
         CHANGE: begin
            reject_n = coin_any;
            if (credit == '0) begin
               state_n = IDLE;
            end else if (bus.hopper_ready) begin
               chg_val  = credit >= CREDIT_W'(25) ? CREDIT_W'(25) :
                          credit >= CREDIT_W'(10) ? CREDIT_W'(10) :
                          credit >= CREDIT_W'(5)  ? CREDIT_W'(5)  : CREDIT_W'(1);
               chg_n    = credit >= CREDIT_W'(25) ? 4'b1000 :
                          credit >= CREDIT_W'(10) ? 4'b0100 :
                          credit >= CREDIT_W'(5)  ? 4'b0010 : 4'b0001;
               credit_n = credit - chg_val;
            end
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         credit      <= '0;
         busy        <= 1'b0;
         dispense    <= 1'b0;
         chg         <= '0;
         reject      <= 1'b0;
         short_funds <= 1'b0;
      end else begin
         state       <= state_n;
         credit      <= credit_n;
         busy        <= state_n == VEND || state_n == CHANGE;
         dispense    <= dispense_n;
         chg         <= chg_n;
         reject      <= reject_n;
         short_funds <= short_n;
      end
   end
`ifdef SALES_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         sales_count  <= '0;
         change_total <= '0;
      end else begin
         sales_count  <= sales_count + 16'(dispense_n);
         change_total <= change_total + 16'(chg_val);
      end
   end
   assign bus.sales_count        = sales_count;
   assign bus.change_cents_total = change_total;
`endif
   assign bus.credit      = credit;
   assign bus.busy        = busy;
   assign bus.dispense    = dispense;
   assign bus.chg_quarter = chg[3];
   assign bus.chg_dime    = chg[2];
   assign bus.chg_nickle  = chg[1];
   assign bus.chg_penny   = chg[0];
   assign bus.reject      = reject;
   assign bus.short_funds = short_funds;
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: table-driven cycle vectors plus a hand-written full-ceiling vend/change sequence.
module tb_vend_controller;
   localparam logic [3:0] Q = 4'b1000, D = 4'b0100, N = 4'b0010, P = 4'b0001, Z = 4'b0000;
   typedef struct {
      logic       rst;
      logic [3:0] coin;
      logic       buy, cancel, hr;
      logic [7:0] credit;
      logic       busy, disp;
      logic [3:0] chg;
      logic       rej, shrt;
   } vec_t;
   logic clk = 1'b0;
   logic reset;
   int   total = 0, bad = 0;
   vec_t tv[$];
   vend_if #(.CREDIT_W(8)) bus ();
   vend_controller #(.PRICE(65), .MAX_CREDIT(200), .CREDIT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   function automatic void add(input logic r, input logic [3:0] c, input logic b, cn, h,
                               input logic [7:0] cr, input logic bz, dp, input logic [3:0] ch,
                               input logic rj, sh);
      tv.push_back('{r, c, b, cn, h, cr, bz, dp, ch, rj, sh});
   endfunction
   task automatic chk(input string name, input logic [31:0] act, exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic drive(input logic r, input logic [3:0] c, input logic b, cn, h);
      reset = r;
      {bus.quarter, bus.dime, bus.nickle, bus.penny} = c;
      bus.buy = b;
      bus.cancel = cn;
      bus.hopper_ready = h;
      @(posedge clk);
      #1;
   endtask
   function automatic logic [15:0] outs();
      return {bus.credit, bus.busy, bus.dispense, bus.chg_quarter, bus.chg_dime,
              bus.chg_nickle, bus.chg_penny, bus.reject, bus.short_funds};
   endfunction
   function automatic int cents(input logic [3:0] c);
      return (c[3] ? 25 : 0) + (c[2] ? 10 : 0) + (c[1] ? 5 : 0) + (c[0] ? 1 : 0);
   endfunction
   initial begin
      int sales_exp = 0, change_exp = 0, sum, nq, nd, pulses;
      logic [3:0] c;
      // rst coin buy cancel hr | credit busy disp chg rej short
      add(1, Z, 0, 0, 0,   0, 0, 0, Z, 0, 0);
      // exact price
      add(0, Q, 0, 0, 0,  25, 0, 0, Z, 0, 0);
      add(0, Q, 0, 0, 0,  50, 0, 0, Z, 0, 0);
      add(0, D, 0, 0, 0,  60, 0, 0, Z, 0, 0);
      add(0, N, 0, 0, 0,  65, 0, 0, Z, 0, 0);
      add(0, Z, 1, 0, 1,   0, 1, 1, Z, 0, 0);
      add(0, Z, 0, 0, 1,   0, 0, 0, Z, 0, 0);
      add(0, Z, 0, 0, 1,   0, 0, 0, Z, 0, 0);
      // vend with a dime of change
      add(0, Q, 0, 0, 1,  25, 0, 0, Z, 0, 0);
      add(0, Q, 0, 0, 1,  50, 0, 0, Z, 0, 0);
      add(0, Q, 0, 0, 1,  75, 0, 0, Z, 0, 0);
      add(0, Z, 1, 0, 1,  10, 1, 1, Z, 0, 0);
      add(0, Z, 0, 0, 1,  10, 1, 0, Z, 0, 0);
      add(0, Z, 0, 0, 1,   0, 1, 0, D, 0, 0);
      add(0, Z, 0, 0, 1,   0, 0, 0, Z, 0, 0);
      // cancel 37 with a hopper stall
      add(0, Q, 0, 0, 0,  25, 0, 0, Z, 0, 0);
      add(0, D, 0, 0, 0,  35, 0, 0, Z, 0, 0);
      add(0, P, 0, 0, 0,  36, 0, 0, Z, 0, 0);
      add(0, P, 0, 0, 0,  37, 0, 0, Z, 0, 0);
      add(0, Z, 0, 1, 0,  37, 1, 0, Z, 0, 0);
      add(0, Z, 0, 0, 1,  12, 1, 0, Q, 0, 0);
      add(0, Z, 0, 0, 0,  12, 1, 0, Z, 0, 0);
      add(0, Z, 0, 0, 1,   2, 1, 0, D, 0, 0);
      add(0, Z, 0, 0, 1,   1, 1, 0, P, 0, 0);
      add(0, Z, 0, 0, 1,   0, 1, 0, P, 0, 0);
      add(0, Z, 0, 0, 1,   0, 0, 0, Z, 0, 0);
      // ceiling, invalid coin, coin during change, reset in change
      for (int i = 1; i <= 8; i++) add(0, Q, 0, 0, 0, 8'(25 * i), 0, 0, Z, 0, 0);
      add(0, Q, 0, 0, 0, 200, 0, 0, Z, 1, 0);
      add(0, D | P, 0, 0, 0, 200, 0, 0, Z, 1, 0);
      add(0, Z, 0, 1, 0, 200, 1, 0, Z, 0, 0);
      add(0, Q, 0, 0, 1, 175, 1, 0, Q, 1, 0);
      add(0, Z, 0, 0, 0, 175, 1, 0, Z, 0, 0);
      add(1, Z, 0, 0, 1,   0, 0, 0, Z, 0, 0);
      // short funds, cancel beats buy
      add(0, Q, 0, 0, 1,  25, 0, 0, Z, 0, 0);
      add(0, Q, 0, 0, 1,  50, 0, 0, Z, 0, 0);
      add(0, Z, 1, 0, 1,  50, 0, 0, Z, 0, 1);
      add(0, Z, 0, 0, 1,  50, 0, 0, Z, 0, 0);
      add(0, Z, 1, 1, 1,  50, 1, 0, Z, 0, 0);
      add(0, Z, 0, 0, 1,  25, 1, 0, Q, 0, 0);
      add(0, Z, 0, 0, 1,   0, 1, 0, Q, 0, 0);
      add(0, Z, 0, 0, 1,   0, 0, 0, Z, 0, 0);
      // reset after the first coin of a 37-cent return
      add(0, Q, 0, 0, 0,  25, 0, 0, Z, 0, 0);
      add(0, D, 0, 0, 0,  35, 0, 0, Z, 0, 0);
      add(0, P, 0, 0, 0,  36, 0, 0, Z, 0, 0);
      add(0, P, 0, 0, 0,  37, 0, 0, Z, 0, 0);
      add(0, Z, 0, 1, 1,  37, 1, 0, Z, 0, 0);
      add(0, Z, 0, 0, 1,  12, 1, 0, Q, 0, 0);
      add(1, Z, 0, 0, 1,   0, 0, 0, Z, 0, 0);
      add(0, Z, 0, 0, 1,   0, 0, 0, Z, 0, 0);
      // buy with a same-cycle coin: the coin joins the change
      add(0, Q, 0, 0, 0,  25, 0, 0, Z, 0, 0);
      add(0, Q, 0, 0, 0,  50, 0, 0, Z, 0, 0);
      add(0, D, 0, 0, 0,  60, 0, 0, Z, 0, 0);
      add(0, N, 0, 0, 0,  65, 0, 0, Z, 0, 0);
      add(0, Q, 1, 0, 0,  25, 1, 1, Z, 0, 0);
      add(0, Z, 0, 0, 1,  25, 1, 0, Z, 0, 0);
      add(0, Z, 0, 0, 1,   0, 1, 0, Q, 0, 0);
      add(0, Z, 0, 0, 1,   0, 0, 0, Z, 0, 0);
      foreach (tv[i]) begin
         drive(tv[i].rst, tv[i].coin, tv[i].buy, tv[i].cancel, tv[i].hr);
         chk($sformatf("vec%0d", i), 32'(outs()),
             32'({tv[i].credit, tv[i].busy, tv[i].disp, tv[i].chg, tv[i].rej, tv[i].shrt}));
         sales_exp  = tv[i].rst ? 0 : sales_exp + int'(tv[i].disp);
         change_exp = tv[i].rst ? 0 : change_exp + cents(tv[i].chg);
`ifdef SALES_COUNT_EN
         chk($sformatf("sales%0d", i), 32'(bus.sales_count), 32'(sales_exp));
         chk($sformatf("chgtot%0d", i), 32'(bus.change_cents_total), 32'(change_exp));
`endif
      end
      // full-ceiling vend: 135 cents of change through an intermittent hopper
      drive(1, Z, 0, 0, 0);
      for (int i = 1; i <= 8; i++) drive(0, Q, 0, 0, 0);
      chk("ceil_credit", 32'(bus.credit), 200);
      drive(0, Z, 1, 0, 0);
      chk("ceil_vend", 32'({bus.credit, bus.dispense, bus.busy}), 32'({8'd135, 1'b1, 1'b1}));
      sum = 0; nq = 0; nd = 0;
      for (int k = 0; k < 60 && bus.busy; k++) begin
         drive(0, Z, 0, 0, k % 3 != 0);
         c = {bus.chg_quarter, bus.chg_dime, bus.chg_nickle, bus.chg_penny};
         pulses = $countones(c);
         if (pulses > 1) chk($sformatf("one_pulse%0d", k), 32'(pulses), 1);
         sum += cents(c);
         nq += int'(c[3]);
         nd += int'(c[2]);
      end
      chk("ceil_idle", 32'({bus.busy, bus.credit}), 0);
      chk("ceil_sum", 32'(sum), 135);
      chk("ceil_mix", 32'({nq[7:0], nd[7:0]}), 32'({8'd5, 8'd1}));
`ifdef SALES_COUNT_EN
      chk("ceil_sales", 32'(bus.sales_count), 1);
      chk("ceil_chgtot", 32'(bus.change_cents_total), 135);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
